// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and hazard controller states.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Port bundle for hazard_unit: hu is the block's view, tb the driver's view.
interface hazard_unit_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic             CLK;
    logic             nRST;
    regbits_t         ID_rs;
    regbits_t         ID_rt;
    regbits_t         EX_wsel;
    logic             EX_MemRead;
    logic             EX_pcsrc;
    logic             MEM_dmemREN;
    logic             MEM_dmemWEN;
    logic             dhit;
    logic             ihit;
    logic             MEM_halt;
    logic             PC_en;
    logic             IFID_en;
    logic             IDEX_en;
    logic             EXMEM_en;
    logic             MEMWB_en;
    logic             IFID_flush;
    logic             IDEX_flush;
    logic             MEMWB_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport hu (
        input  CLK, nRST, ID_rs, ID_rt, EX_wsel, EX_MemRead, EX_pcsrc,
               MEM_dmemREN, MEM_dmemWEN, dhit, ihit, MEM_halt,
        output PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
               IFID_flush, IDEX_flush, MEMWB_flush, halted,
               stall_cycles, flush_events
    );

    modport tb (
        output CLK, nRST, ID_rs, ID_rt, EX_wsel, EX_MemRead, EX_pcsrc,
               MEM_dmemREN, MEM_dmemWEN, dhit, ihit, MEM_halt,
        input  PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
               IFID_flush, IDEX_flush, MEMWB_flush, halted,
               stall_cycles, flush_events
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones and can be frozen.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         freeze,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && !freeze && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline, with saturating
// stall-cycle and branch-flush counters.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  regbits_t         ID_rs,
    input  regbits_t         ID_rt,
    input  regbits_t         EX_wsel,
    input  logic             EX_MemRead,
    input  logic             EX_pcsrc,
    input  logic             MEM_dmemREN,
    input  logic             MEM_dmemWEN,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             MEM_halt,
    output logic             PC_en,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             MEMWB_en,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             MEMWB_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    hazard_state_t state, next_state;
    logic          dwait;
    logic          load_use;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= RUN;
        else
            state <= next_state;
    end

    always_comb begin
        dwait    = (MEM_dmemREN | MEM_dmemWEN) & ~dhit;
        load_use = EX_MemRead && (EX_wsel != '0) &&
                   ((EX_wsel == ID_rs) || (EX_wsel == ID_rt));

        next_state = state;
        unique case (state)
            RUN: begin
                if (MEM_halt && !dwait)
                    next_state = HALTED;
                else if (dwait)
                    next_state = DWAIT;
            end
            DWAIT: begin
                if (MEM_halt && !dwait)
                    next_state = HALTED;
                else if (dhit)
                    next_state = RUN;
            end
            HALTED: next_state = HALTED;
            default: next_state = RUN;
        endcase

        PC_en       = 1'b1;
        IFID_en     = 1'b1;
        IDEX_en     = 1'b1;
        EXMEM_en    = 1'b1;
        MEMWB_en    = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        MEMWB_flush = 1'b0;

        // Reset and halt both freeze every latch; otherwise the first
        // matching hazard wins, and a pending branch waits out a dwait.
        if (!nRST || (state == HALTED)) begin
            PC_en    = 1'b0;
            IFID_en  = 1'b0;
            IDEX_en  = 1'b0;
            EXMEM_en = 1'b0;
            MEMWB_en = 1'b0;
        end else if (dwait) begin
            PC_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_en     = 1'b0;
            EXMEM_en    = 1'b0;
            MEMWB_flush = 1'b1;
        end else if (EX_pcsrc) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (load_use) begin
            PC_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
        end else if (!ihit) begin
            PC_en      = 1'b0;
            IFID_flush = 1'b1;
        end
    end

    assign halted = (state == HALTED);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (CLK),
        .rst_n  (nRST),
        .inc    (!PC_en),
        .freeze (halted),
        .count  (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (CLK),
        .rst_n  (nRST),
        .inc    (EX_pcsrc && !dwait),
        .freeze (halted),
        .count  (flush_events)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit against a rule-level model.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic     rst_n;
        regbits_t rs;
        regbits_t rt;
        regbits_t wsel;
        logic     memread;
        logic     pcsrc;
        logic     ren;
        logic     wen;
        logic     dhit;
        logic     ihit;
        logic     halt;
    } stim_t;

    typedef struct packed {
        logic          pc_en;
        logic          ifid_en;
        logic          idex_en;
        logic          exmem_en;
        logic          memwb_en;
        logic          ifid_flush;
        logic          idex_flush;
        logic          memwb_flush;
        logic          halted;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } obs_t;

    hazard_unit_if #(.CNT_W(CW)) hif ();

    hazard_unit #(.CNT_W(CW)) dut (
        .CLK          (hif.CLK),
        .nRST         (hif.nRST),
        .ID_rs        (hif.ID_rs),
        .ID_rt        (hif.ID_rt),
        .EX_wsel      (hif.EX_wsel),
        .EX_MemRead   (hif.EX_MemRead),
        .EX_pcsrc     (hif.EX_pcsrc),
        .MEM_dmemREN  (hif.MEM_dmemREN),
        .MEM_dmemWEN  (hif.MEM_dmemWEN),
        .dhit         (hif.dhit),
        .ihit         (hif.ihit),
        .MEM_halt     (hif.MEM_halt),
        .PC_en        (hif.PC_en),
        .IFID_en      (hif.IFID_en),
        .IDEX_en      (hif.IDEX_en),
        .EXMEM_en     (hif.EXMEM_en),
        .MEMWB_en     (hif.MEMWB_en),
        .IFID_flush   (hif.IFID_flush),
        .IDEX_flush   (hif.IDEX_flush),
        .MEMWB_flush  (hif.MEMWB_flush),
        .halted       (hif.halted),
        .stall_cycles (hif.stall_cycles),
        .flush_events (hif.flush_events)
    );

    initial hif.CLK = 1'b0;
    always #5 hif.CLK = ~hif.CLK;

    // Reference model: halted flag and two saturating counts.
    bit   m_halted;
    int   m_stall;
    int   m_flush;
    obs_t exp_q[$];
    event sampled;
    int   checks;
    int   errors;
    int   cyc;

    function automatic obs_t model_out(input stim_t s);
        obs_t o;
        bit   dw;
        bit   lu;
        o = '0;
        o.stall = m_stall[CW-1:0];
        o.flush = m_flush[CW-1:0];
        if (!s.rst_n) begin
            o.stall = '0;
            o.flush = '0;
            return o;
        end
        if (m_halted) begin
            o.halted = 1'b1;
            return o;
        end
        {o.pc_en, o.ifid_en, o.idex_en, o.exmem_en, o.memwb_en} = 5'b11111;
        dw = (s.ren || s.wen) && !s.dhit;
        lu = s.memread && s.wsel != 0 && (s.wsel == s.rs || s.wsel == s.rt);
        if (dw) begin
            {o.pc_en, o.ifid_en, o.idex_en, o.exmem_en} = 4'b0000;
            o.memwb_flush = 1'b1;
        end else if (s.pcsrc) begin
            o.ifid_flush = 1'b1;
            o.idex_flush = 1'b1;
        end else if (lu) begin
            o.pc_en      = 1'b0;
            o.ifid_en    = 1'b0;
            o.idex_flush = 1'b1;
        end else if (!s.ihit) begin
            o.pc_en      = 1'b0;
            o.ifid_flush = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step(input stim_t s, input obs_t o);
        bit dw;
        dw = (s.ren || s.wen) && !s.dhit;
        if (!s.rst_n) begin
            m_halted = 0;
            m_stall  = 0;
            m_flush  = 0;
        end else if (!m_halted) begin
            if (!o.pc_en && m_stall < CMAX) m_stall++;
            if (s.pcsrc && !dw && m_flush < CMAX) m_flush++;
            if (s.halt && !dw) m_halted = 1;
        end
    endtask

    task automatic cycle(input stim_t s);
        obs_t e;
        @(negedge hif.CLK);
        hif.nRST        = s.rst_n;
        hif.ID_rs       = s.rs;
        hif.ID_rt       = s.rt;
        hif.EX_wsel     = s.wsel;
        hif.EX_MemRead  = s.memread;
        hif.EX_pcsrc    = s.pcsrc;
        hif.MEM_dmemREN = s.ren;
        hif.MEM_dmemWEN = s.wen;
        hif.dhit        = s.dhit;
        hif.ihit        = s.ihit;
        hif.MEM_halt    = s.halt;
        #1;
        e = model_out(s);
        exp_q.push_back(e);
        -> sampled;
        @(posedge hif.CLK);
        model_step(s, e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        s.dhit  = 1'b1;
        s.ihit  = 1'b1;
        return s;
    endfunction

    task automatic repeat_cycle(input stim_t s, input int n);
        for (int i = 0; i < n; i++) cycle(s);
    endtask

    // Monitor: compares every presented output set against the queue head.
    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(sampled);
            #1;
            a = {hif.PC_en, hif.IFID_en, hif.IDEX_en, hif.EXMEM_en, hif.MEMWB_en,
                 hif.IFID_flush, hif.IDEX_flush, hif.MEMWB_flush, hif.halted,
                 hif.stall_cycles, hif.flush_events};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty cycle %0d: got %h, no expectation queued", cyc, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %b_%h_%h, required %b_%h_%h",
                             cyc, a[16:8], a.stall, a.flush, e[16:8], e.stall, e.flush);
                end
            end
            cyc++;
        end
    end

    initial begin
        stim_t s;
        checks = 0;
        errors = 0;
        cyc    = 0;
        m_halted = 0;
        m_stall  = 0;
        m_flush  = 0;
        hif.nRST = 1'b0;

        s = idle(); s.rst_n = 0; s.pcsrc = 1;
        repeat_cycle(s, 2);
        repeat_cycle(idle(), 2);

        s = idle(); s.memread = 1; s.wsel = 5; s.rt = 5;
        cycle(s);
        cycle(idle());
        s.wsel = 0; s.rt = 0;
        cycle(s);
        cycle(idle());

        s = idle(); s.pcsrc = 1; s.ihit = 0; s.memread = 1; s.wsel = 7; s.rs = 7;
        cycle(s);
        cycle(idle());

        s = idle(); s.ren = 1; s.dhit = 0;
        repeat_cycle(s, 3);
        s.dhit = 1;
        cycle(s);
        repeat_cycle(idle(), 2);

        s = idle(); s.halt = 1;
        cycle(s);
        repeat_cycle(idle(), 10);
        s = idle(); s.rst_n = 0;
        cycle(s);
        repeat_cycle(idle(), 2);

        s = idle(); s.ihit = 0;
        repeat_cycle(s, 20);
        cycle(idle());

        s = idle(); s.rst_n = 0;
        cycle(s);
        s = idle(); s.wen = 1; s.dhit = 0; s.pcsrc = 1;
        repeat_cycle(s, 2);
        s.wen = 0; s.dhit = 1;
        cycle(s);
        s = idle(); s.ren = 1; s.dhit = 0; s.halt = 1;
        repeat_cycle(s, 2);
        s.dhit = 1;
        cycle(s);
        repeat_cycle(idle(), 2);
        s = idle(); s.rst_n = 0;
        cycle(s);
        s = idle(); s.ren = 1; s.dhit = 0;
        repeat_cycle(s, 2);
        s.rst_n = 0;
        cycle(s);
        repeat_cycle(idle(), 2);

        for (int i = 0; i < 3000; i++) begin
            s         = idle();
            s.rs      = regbits_t'($urandom_range(0, 3));
            s.rt      = regbits_t'($urandom_range(0, 3));
            s.wsel    = regbits_t'($urandom_range(0, 3));
            s.memread = ($urandom_range(0, 99) < 35);
            s.pcsrc   = ($urandom_range(0, 99) < 15);
            s.ren     = ($urandom_range(0, 99) < 20);
            s.wen     = ($urandom_range(0, 99) < 10);
            s.dhit    = ($urandom_range(0, 99) < 50);
            s.ihit    = ($urandom_range(0, 99) < 75);
            s.halt    = ($urandom_range(0, 99) < 3);
            if (m_halted) s.rst_n = ($urandom_range(0, 99) >= 20);
            else          s.rst_n = ($urandom_range(0, 99) >= 2);
            cycle(s);
        end

        @(negedge hif.CLK);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
